// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exc_ctrl
// Brief    : CP0 exception/interrupt controller (M stage): SR, Cause, EPC,
//            PRId, request generation, mfc0/mtc0 and eret handling.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID_VAL   = 32'h2024_0707,
  parameter bit          INT_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0_addr,
  input  logic [31:0] CP0_in,
  output logic [31:0] CP0_out,
  input  logic [31:0] VPC,
  input  logic        BD_in,
  input  logic [4:0]  ExcCode_in,
  input  logic [5:0]  HWInt,
  input  logic        EXL_clr,
  output logic        req,
  output logic [31:0] EPC_out
);

  localparam logic [4:0] c_ADDR_SR    = 5'd12;
  localparam logic [4:0] c_ADDR_CAUSE = 5'd13;
  localparam logic [4:0] c_ADDR_EPC   = 5'd14;
  localparam logic [4:0] c_ADDR_PRID  = 5'd15;

  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_unused_in;

  assign w_int_req = INT_ENABLE & (|(HWInt & r_sr_im)) & r_sr_ie & ~r_sr_exl;
  assign w_exc_req = (ExcCode_in != 5'd0) & ~r_sr_exl;

  // Gated by reset so a pending ExcCode cannot raise req while state is cleared.
  assign req     = reset & (w_int_req | w_exc_req);
  assign EPC_out = r_epc;

  assign w_unused_in = ^{CP0_in[31:16], CP0_in[9:2]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr_im     <= 6'd0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= 6'd0;
      r_cause_exc <= 5'd0;
      r_epc       <= 32'd0;
    end else begin
      r_cause_ip <= HWInt;
      if (req) begin
        // Taking the exception/interrupt discards any mtc0 or eret this cycle.
        r_sr_exl    <= 1'b1;
        r_cause_bd  <= BD_in;
        r_cause_exc <= w_int_req ? 5'd0 : ExcCode_in;
        r_epc       <= BD_in ? (VPC - 32'd4) : VPC;
      end else begin
        if (en && (CP0_addr == c_ADDR_SR)) begin
          r_sr_im  <= CP0_in[15:10];
          r_sr_exl <= CP0_in[1];
          r_sr_ie  <= CP0_in[0];
        end
        if (en && (CP0_addr == c_ADDR_EPC)) begin
          r_epc <= CP0_in;
        end
        if (EXL_clr) begin
          r_sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    CP0_out = 32'd0;
    case (CP0_addr)
      c_ADDR_SR:    CP0_out = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
      c_ADDR_CAUSE: CP0_out = {r_cause_bd, 15'd0, r_cause_ip, 3'd0, r_cause_exc, 2'd0};
      c_ADDR_EPC:   CP0_out = r_epc;
      c_ADDR_PRID:  CP0_out = PRID_VAL;
      default:      CP0_out = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_exc_ctrl
// Brief    : Self-checking bench for cp0_exc_ctrl: directed scenarios plus
//            randomized traffic against a register-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_ctrl;

  localparam logic [31:0] c_PRID = 32'h2024_0707;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0_addr;
  logic [31:0] CP0_in;
  logic [31:0] CP0_out;
  logic [31:0] VPC;
  logic        BD_in;
  logic [4:0]  ExcCode_in;
  logic [5:0]  HWInt;
  logic        EXL_clr;
  logic        req;
  logic [31:0] EPC_out;

  int n_cmp  = 0;
  int n_fail = 0;

  // Architectural view of the registers as whole 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exc_ctrl #(.PRID_VAL(c_PRID), .INT_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .CP0_addr(CP0_addr), .CP0_in(CP0_in),
    .CP0_out(CP0_out), .VPC(VPC), .BD_in(BD_in), .ExcCode_in(ExcCode_in),
    .HWInt(HWInt), .EXL_clr(EXL_clr), .req(req), .EPC_out(EPC_out)
  );

  always #10 clk = ~clk;

  function automatic logic m_int();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return reset && (m_int() || ((ExcCode_in != 5'd0) && !m_sr[1]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return c_PRID;
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock: compute the model's next state from the current inputs,
  // then let the edge happen and leave the caller 1 ns after it.
  task automatic step();
    logic [31:0] ns, nc, ne;
    ns = m_sr; nc = m_cause; ne = m_epc;
    nc = (nc & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
    if (m_req()) begin
      ns = ns | 32'h2;
      nc[31] = BD_in;
      nc[6:2] = m_int() ? 5'd0 : ExcCode_in;
      ne = BD_in ? VPC - 32'd4 : VPC;
    end else begin
      if (en && CP0_addr == 5'd12) ns = CP0_in & 32'h0000_FC03;
      if (en && CP0_addr == 5'd14) ne = CP0_in;
      if (EXL_clr) ns = ns & ~32'h2;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      m_sr = ns; m_cause = nc; m_epc = ne;
    end else begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end
  endtask

  task automatic idle_inputs();
    en = 0; CP0_addr = 0; CP0_in = 0; VPC = 0; BD_in = 0;
    ExcCode_in = 0; HWInt = 0; EXL_clr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    HWInt = 6'h3F; ExcCode_in = 5'd4;
    #1;
    n_cmp++; if (req !== 1'b1) begin $display("FAIL rst_pre_req got=%b exp=1", req); n_fail++; end
    reset = 0;
    #1;
    n_cmp++; if (req !== 1'b0) begin $display("FAIL rst_req got=%b exp=0", req); n_fail++; end
    n_cmp++; if (EPC_out !== 32'd0) begin $display("FAIL rst_epc_out got=%h exp=0", EPC_out); n_fail++; end
    for (int a = 12; a <= 14; a++) begin
      CP0_addr = 5'(a);
      #1;
      n_cmp++; if (CP0_out !== 32'd0) begin $display("FAIL rst_read%0d got=%h exp=0", a, CP0_out); n_fail++; end
    end
    step();
    reset = 1;
    idle_inputs();
  endtask

  task automatic test_exc_bd();
    ExcCode_in = 5'd10; VPC = 32'h0000_3010; BD_in = 1;
    #1;
    n_cmp++; if (req !== 1'b1) begin $display("FAIL exc_req got=%b exp=1", req); n_fail++; end
    step();
    ExcCode_in = 0; BD_in = 0;
    CP0_addr = 14; #1;
    n_cmp++; if (CP0_out !== 32'h0000_300C) begin $display("FAIL exc_epc got=%h exp=0000300c", CP0_out); n_fail++; end
    CP0_addr = 13; #1;
    n_cmp++; if (CP0_out !== 32'h8000_0028) begin $display("FAIL exc_cause got=%h exp=80000028", CP0_out); n_fail++; end
    CP0_addr = 12; #1;
    n_cmp++; if (CP0_out !== 32'h0000_0002) begin $display("FAIL exc_sr got=%h exp=00000002", CP0_out); n_fail++; end
    ExcCode_in = 5'd10; #1;
    n_cmp++; if (req !== 1'b0) begin $display("FAIL exc_reentry got=%b exp=0", req); n_fail++; end
    ExcCode_in = 0;
  endtask

  task automatic test_int_priority();
    EXL_clr = 1; step(); EXL_clr = 0;
    en = 1; CP0_addr = 12; CP0_in = 32'h0000_0401; step(); en = 0;
    HWInt = 6'h01; ExcCode_in = 5'd4; VPC = 32'h0000_3020; BD_in = 0;
    #1;
    n_cmp++; if (req !== 1'b1) begin $display("FAIL int_req got=%b exp=1", req); n_fail++; end
    step();
    ExcCode_in = 0;
    CP0_addr = 13; #1;
    n_cmp++; if (CP0_out !== 32'h0000_0400) begin $display("FAIL int_cause got=%h exp=00000400", CP0_out); n_fail++; end
    CP0_addr = 14; #1;
    n_cmp++; if (CP0_out !== 32'h0000_3020) begin $display("FAIL int_epc got=%h exp=00003020", CP0_out); n_fail++; end
    HWInt = 0;
  endtask

  task automatic test_masking();
    EXL_clr = 1; en = 1; CP0_addr = 12; CP0_in = 32'h0000_0001; HWInt = 6'h3F;
    step();
    EXL_clr = 0; en = 0; #1;
    n_cmp++; if (req !== 1'b0) begin $display("FAIL mask_im0 got=%b exp=0", req); n_fail++; end
    step();
    CP0_addr = 13; #1;
    n_cmp++; if (CP0_out[15:10] !== 6'h3F) begin $display("FAIL mask_ip got=%h exp=3f", CP0_out[15:10]); n_fail++; end
    en = 1; CP0_addr = 12; CP0_in = 32'h0000_FC00; step(); en = 0; #1;
    n_cmp++; if (req !== 1'b0) begin $display("FAIL mask_ie0 got=%b exp=0", req); n_fail++; end
    en = 1; CP0_in = 32'h0000_FC01; #1;
    n_cmp++; if (req !== 1'b0) begin $display("FAIL mask_write_cycle got=%b exp=0", req); n_fail++; end
    step(); en = 0; #1;
    n_cmp++; if (req !== 1'b1) begin $display("FAIL mask_enabled got=%b exp=1", req); n_fail++; end
    step(); #1;
    n_cmp++; if (req !== 1'b0) begin $display("FAIL mask_no_retrigger got=%b exp=0", req); n_fail++; end
  endtask

  task automatic test_eret();
    HWInt = 0; EXL_clr = 1;
    step();
    EXL_clr = 0; CP0_addr = 12; #1;
    n_cmp++; if (CP0_out[1] !== 1'b0) begin $display("FAIL eret_exl got=%b exp=0", CP0_out[1]); n_fail++; end
    n_cmp++; if (EPC_out !== 32'h0000_3020) begin $display("FAIL eret_epc got=%h exp=00003020", EPC_out); n_fail++; end
    ExcCode_in = 5'd5; step();
    ExcCode_in = 5'd12; EXL_clr = 1; #1;
    n_cmp++; if (req !== 1'b0) begin $display("FAIL eret_coll_req got=%b exp=0", req); n_fail++; end
    step();
    ExcCode_in = 0; EXL_clr = 0; #1;
    n_cmp++; if (CP0_out[1] !== 1'b0) begin $display("FAIL eret_coll_exl got=%b exp=0", CP0_out[1]); n_fail++; end
  endtask

  task automatic test_collision();
    en = 1; CP0_addr = 14; CP0_in = 32'h0000_1234;
    ExcCode_in = 5'd8; VPC = 32'h0000_3040; BD_in = 0;
    #1;
    n_cmp++; if (req !== 1'b1) begin $display("FAIL coll_req got=%b exp=1", req); n_fail++; end
    step();
    en = 0; ExcCode_in = 0; #1;
    n_cmp++; if (CP0_out !== 32'h0000_3040) begin $display("FAIL coll_epc got=%h exp=00003040", CP0_out); n_fail++; end
    CP0_addr = 15; #1;
    n_cmp++; if (CP0_out !== c_PRID) begin $display("FAIL prid got=%h exp=%h", CP0_out, c_PRID); n_fail++; end
    CP0_addr = 7; #1;
    n_cmp++; if (CP0_out !== 32'd0) begin $display("FAIL read_other got=%h exp=0", CP0_out); n_fail++; end
    EXL_clr = 1; step(); EXL_clr = 0;
    ExcCode_in = 5'd1; VPC = 32'd0; BD_in = 1; step();
    ExcCode_in = 0; BD_in = 0; #1;
    n_cmp++; if (EPC_out !== 32'hFFFF_FFFC) begin $display("FAIL epc_wrap got=%h exp=fffffffc", EPC_out); n_fail++; end
    EXL_clr = 1; step(); EXL_clr = 0;
  endtask

  task automatic test_random();
    logic [4:0] addrs [6];
    addrs = '{5'd12, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
    for (int i = 0; i < 400; i++) begin
      HWInt      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      ExcCode_in = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'd0;
      EXL_clr    = ($urandom_range(0, 5) == 0);
      en         = ($urandom_range(0, 2) == 0);
      CP0_addr   = addrs[$urandom_range(0, 5)];
      if (CP0_addr == 5'd0) CP0_addr = 5'($urandom);
      CP0_in     = $urandom;
      VPC        = $urandom;
      BD_in      = 1'($urandom);
      #1;
      if ($urandom_range(0, 49) == 0) begin
        reset = 0; #1;
        n_cmp++; if (req !== 1'b0) begin $display("FAIL rnd_rst_req i=%0d got=%b exp=0", i, req); n_fail++; end
        n_cmp++; if (EPC_out !== 32'd0) begin $display("FAIL rnd_rst_epc i=%0d got=%h exp=0", i, EPC_out); n_fail++; end
        step();
        reset = 1;
      end else begin
        n_cmp++; if (req !== m_req()) begin $display("FAIL rnd_req i=%0d got=%b exp=%b", i, req, m_req()); n_fail++; end
        n_cmp++; if (CP0_out !== m_read(CP0_addr)) begin $display("FAIL rnd_read i=%0d addr=%0d got=%h exp=%h", i, CP0_addr, CP0_out, m_read(CP0_addr)); n_fail++; end
        n_cmp++; if (EPC_out !== m_epc) begin $display("FAIL rnd_epc_out i=%0d got=%h exp=%h", i, EPC_out, m_epc); n_fail++; end
        step();
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_exc_bd();
    test_int_priority();
    test_masking();
    test_eret();
    test_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller in the M stage of the 5-stage MIPS pipeline.
- Collects the exception code and BD flag carried down the pipeline, plus the six hardware interrupt lines.
- Raises the single-cycle `req` that the fetch-side PC register consumes to redirect to the handler, and records EPC, Cause and SR.
- Serves mfc0/mtc0 accesses and eret (EPC readback, EXL clear).

Parameters:
- PRID_VAL, 32'h2024_0707: read-only value returned for PRId (reg 15).
- INT_ENABLE, 1: 0 disables interrupt recognition entirely (exceptions only).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset, applied immediately, released synchronously to clk)
- en  input  1  mtc0 write enable (M stage)
- CP0_addr  input  5  CP0 register number for mfc0/mtc0
- CP0_in  input  32  mtc0 write data
- CP0_out  output  32  mfc0 read data, combinational from CP0_addr
- VPC  input  32  PC of the instruction currently in M stage
- BD_in  input  1  M-stage instruction is in a branch delay slot
- ExcCode_in  input  5  M-stage exception code, 0 = none
- HWInt  input  6  hardware interrupt lines, level-sensitive
- EXL_clr  input  1  eret in M stage
- req  output  1  exception/interrupt request to PC and pipeline flush
- EPC_out  output  32  current EPC value, for eret target

Behaviour:
- Stored state:
  - SR (reg 12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (reg 13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (reg 14): 32 bits.
- Reset (reset=0, asynchronous): SR=0, Cause=0, EPC=0. While reset is low, req=0, CP0_out is per the combinational read of the zeroed registers, and EPC_out=0.
- Interrupt pending: int_req = INT_ENABLE & |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- Exception pending: exc_req = (ExcCode_in != 0) & ~SR.EXL.
- req = int_req | exc_req, combinational, same cycle as the M-stage inputs. The PC register samples it at the next edge.
- Priority: an interrupt beats a synchronous exception in the same cycle.
- On the edge where req=1:
  - EXL<=1.
  - Cause.BD<=BD_in.
  - Cause.ExcCode<=int_req?0:ExcCode_in.
  - EPC<=BD_in?VPC-4:VPC (32-bit wrap; VPC=0 with BD gives 32'hFFFF_FFFC).
- Cause.IP<=HWInt every edge, regardless of req or EXL.
- mtc0 (en=1, req=0) at the edge:
  - addr 12 updates IM, EXL, IE from CP0_in.
  - addr 14 writes EPC fully.
  - addr 13, 15 and any other address are ignored.
- Simultaneous events:
  - req and en in the same cycle: req update wins, the mtc0 write is discarded.
  - req and EXL_clr in the same cycle: req wins, EXL stays 1.
  - EXL_clr alone: EXL<=0 at the edge. This is the only path besides mtc0 to clear EXL.
- Reads:
  - CP0_out combinational: 12→SR, 13→Cause, 14→EPC, 15→PRID_VAL, others→0.
  - A value written by mtc0 becomes visible on CP0_out the cycle after the write edge. No internal bypass; the pipeline forwards.
- Level behaviour:
  - req is purely level; it is not held internally.
  - After the taking edge EXL=1 suppresses re-entry until eret, so a persistent HWInt does not retrigger.
- Reset asserted mid-cycle with req high: all state clears immediately and req drops.

Test Plan:
- Reset: drive reset=0 with HWInt=6'h3F and ExcCode_in=4 → req=0, CP0_out=0 for addr 12/13/14, EPC_out=0.
- Exception with BD: SR=0, ExcCode_in=10, VPC=32'h0000_3010, BD_in=1 → req=1 that cycle. Next cycle: EPC=32'h0000_300C, Cause=32'h8000_0028, SR.EXL=1. A repeat ExcCode_in=10 then gives req=0.
- Interrupt priority: mtc0 SR=32'h0000_0401, then HWInt=6'h01 with ExcCode_in=4, VPC=32'h3020 → req=1. Next cycle: Cause.ExcCode=0, IP=6'h01 (Cause=32'h0000_0400), EPC=32'h3020.
- Masking: SR.IM=0 or IE=0 with HWInt=6'h3F → req=0 and Cause.IP=6'h3F. Set IE with IM=6'h3F → req=1 in the cycle after the mtc0 edge.
- eret: with EXL=1 pulse EXL_clr → EXL=0 next cycle, EPC_out unchanged. Pulse EXL_clr together with a new ExcCode_in=12 while EXL=1 → req=0 that cycle (EXL still set), and EXL=0 after the edge.
- Collision: en=1, addr=14, CP0_in=32'h1234 in the same cycle as ExcCode_in=8, VPC=32'h3040, BD_in=0 → EPC=32'h3040, not 32'h1234. mfc0 addr 15 returns PRID_VAL, addr 7 returns 0.
